line_stepper_gen: RTL and testbench

//  All-octant Bresenham line rasteriser; successor to the single-octant stepper in the lab3 display path.

---
 rtl/line_pkg.sv | 18 +
 rtl/line_octant_setup.sv | 28 ++
 rtl/line_stepper_gen.sv | 146 ++++++++++++++
 tb/tb_line_stepper_gen.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/line_pkg.sv
// Shared types and default geometry for the line rasteriser.
// Optional clipping build: define LINE_CLIP_EN.
package line_pkg;

   localparam int unsigned DefCw   = 11;
   localparam int unsigned DefScrW = 640;
   localparam int unsigned DefScrH = 480;

   typedef logic [DefCw-1:0] coord_t;

   typedef enum logic [1:0] {
      StIdle,
      StSetup,
      StDraw,
      StDone
   } line_state_t;

endpackage

// File: rtl/line_octant_setup.sv
// Combinational octant decode for Bresenham: absolute deltas, step directions
// and initial error term from a pair of unsigned endpoints.
module line_octant_setup
   import line_pkg::*;
#(
   parameter int unsigned CW = DefCw
) (
   input  logic [CW-1:0]        x0,
   input  logic [CW-1:0]        y0,
   input  logic [CW-1:0]        x1,
   input  logic [CW-1:0]        y1,
   output logic [CW-1:0]        dx,
   output logic [CW-1:0]        dy,
   output logic                 sx_neg,
   output logic                 sy_neg,
   output logic signed [CW+1:0] err_init
);

   always_comb begin
      sx_neg   = (x1 < x0);
      sy_neg   = (y1 < y0);
      dx       = sx_neg ? (x0 - x1) : (x1 - x0);
      dy       = sy_neg ? (y0 - y1) : (y1 - y0);
      // Two guard bits keep dx-dy exact for full-range coordinates
      err_init = $signed({2'b00, dx}) - $signed({2'b00, dy});
   end

endmodule

// File: rtl/line_stepper_gen.sv
// All-octant Bresenham line rasteriser with start/busy command side and a
// valid/ready pixel stream. Define LINE_CLIP_EN to suppress off-screen pixels.
module line_stepper_gen
   import line_pkg::*;
#(
   parameter int unsigned CW    = DefCw,
   parameter int unsigned SCR_W = DefScrW,
   parameter int unsigned SCR_H = DefScrH
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          start,
   input  logic [CW-1:0] x0,
   input  logic [CW-1:0] y0,
   input  logic [CW-1:0] x1,
   input  logic [CW-1:0] y1,
   output logic          busy,
   output logic          pix_valid,
   input  logic          pix_ready,
   output logic [CW-1:0] x,
   output logic [CW-1:0] y,
   output logic          done
);

   line_state_t state_q;

   logic [CW-1:0]        x0_q, y0_q, x1_q, y1_q;
   logic [CW-1:0]        dx_q, dy_q;
   logic                 sx_neg_q, sy_neg_q;
   logic signed [CW+1:0] err_q;

   logic [CW-1:0]        dx_s, dy_s;
   logic                 sx_neg_s, sy_neg_s;
   logic signed [CW+1:0] err_init_s;

   line_octant_setup #(
      .CW (CW)
   ) u_setup (
      .x0       (x0_q),
      .y0       (y0_q),
      .x1       (x1_q),
      .y1       (y1_q),
      .dx       (dx_s),
      .dy       (dy_s),
      .sx_neg   (sx_neg_s),
      .sy_neg   (sy_neg_s),
      .err_init (err_init_s)
   );

   logic signed [CW+2:0] e2, dx_e2, dy_e2;
   logic signed [CW+1:0] err_nxt;
   logic                 step_x, step_y;
   logic [CW-1:0]        x_nxt, y_nxt;
   logic                 last_pix, advance, vis_start, vis_next;

   always_comb begin
      e2       = $signed({err_q, 1'b0});
      dx_e2    = $signed({3'b000, dx_q});
      dy_e2    = $signed({3'b000, dy_q});
      step_x   = (e2 >= -dy_e2);
      step_y   = (e2 <= dx_e2);
      err_nxt  = err_q;
      if (step_x) err_nxt = err_nxt - $signed({2'b00, dy_q});
      if (step_y) err_nxt = err_nxt + $signed({2'b00, dx_q});
      x_nxt    = x;
      y_nxt    = y;
      if (step_x) x_nxt = sx_neg_q ? (x - CW'(1)) : (x + CW'(1));
      if (step_y) y_nxt = sy_neg_q ? (y - CW'(1)) : (y + CW'(1));
      last_pix = (x == x1_q) && (y == y1_q);
`ifdef LINE_CLIP_EN
      // Off-screen coordinates are never shown, so they step without a handshake
      advance   = pix_valid ? pix_ready : 1'b1;
      vis_start = (x0_q < CW'(SCR_W)) && (y0_q < CW'(SCR_H));
      vis_next  = (x_nxt < CW'(SCR_W)) && (y_nxt < CW'(SCR_H));
`else
      advance   = pix_valid && pix_ready;
      vis_start = 1'b1;
      vis_next  = 1'b1;
`endif
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= StIdle;
         busy      <= 1'b0;
         pix_valid <= 1'b0;
         done      <= 1'b0;
         x         <= '0;
         y         <= '0;
         err_q     <= '0;
         x0_q      <= '0;
         y0_q      <= '0;
         x1_q      <= '0;
         y1_q      <= '0;
         dx_q      <= '0;
         dy_q      <= '0;
         sx_neg_q  <= 1'b0;
         sy_neg_q  <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  x0_q    <= x0;
                  y0_q    <= y0;
                  x1_q    <= x1;
                  y1_q    <= y1;
                  busy    <= 1'b1;
                  state_q <= StSetup;
               end
            end
            StSetup: begin
               dx_q      <= dx_s;
               dy_q      <= dy_s;
               sx_neg_q  <= sx_neg_s;
               sy_neg_q  <= sy_neg_s;
               err_q     <= err_init_s;
               x         <= x0_q;
               y         <= y0_q;
               pix_valid <= vis_start;
               state_q   <= StDraw;
            end
            StDraw: begin
               if (advance) begin
                  if (last_pix) begin
                     pix_valid <= 1'b0;
                     done      <= 1'b1;
                     state_q   <= StDone;
                  end else begin
                     x         <= x_nxt;
                     y         <= y_nxt;
                     err_q     <= err_nxt;
                     pix_valid <= vis_next;
                  end
               end
            end
            StDone: begin
               busy    <= 1'b0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_line_stepper_gen.sv
// Scoreboard bench for line_stepper_gen; honours LINE_CLIP_EN for the clipping case.
module tb_line_stepper_gen;

   localparam int CW = 11;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          start;
   logic [CW-1:0] x0, y0, x1, y1;
   logic          busy, pix_valid, pix_ready, done;
   logic [CW-1:0] x, y;

   bit [2*CW-1:0] sb[$];
   int            n_tests = 0;
   int            n_fail  = 0;

   line_stepper_gen dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .x0        (x0),
      .y0        (y0),
      .x1        (x1),
      .y1        (y1),
      .busy      (busy),
      .pix_valid (pix_valid),
      .pix_ready (pix_ready),
      .x         (x),
      .y         (y),
      .done      (done)
   );

   always #5 clk = ~clk;

   function automatic bit on_screen(input int px, input int py);
`ifdef LINE_CLIP_EN
      return (px < 640) && (py < 480);
`else
      return 1'b1;
`endif
   endfunction

   // Reference Bresenham walk producing the expected pixel stream
   task automatic push_line(input int ax0, input int ay0, input int ax1, input int ay1);
      int dx, dy, sx, sy, err, e2, cx, cy;
      dx  = (ax1 >= ax0) ? ax1 - ax0 : ax0 - ax1;
      dy  = (ay1 >= ay0) ? ay1 - ay0 : ay0 - ay1;
      sx  = (ax1 >= ax0) ? 1 : -1;
      sy  = (ay1 >= ay0) ? 1 : -1;
      err = dx - dy;
      cx  = ax0;
      cy  = ay0;
      for (int i = 0; i < 5000; i++) begin
         if (on_screen(cx, cy)) sb.push_back({cx[CW-1:0], cy[CW-1:0]});
         if (cx == ax1 && cy == ay1) break;
         e2 = 2 * err;
         if (e2 >= -dy) begin err -= dy; cx += sx; end
         if (e2 <= dx)  begin err += dx; cy += sy; end
      end
   endtask

   // Caller sits just after a rising edge; returns just after the accepting edge
   task automatic start_line(input int ax0, input int ay0, input int ax1, input int ay1);
      push_line(ax0, ay0, ax1, ay1);
      x0 = ax0[CW-1:0]; y0 = ay0[CW-1:0];
      x1 = ax1[CW-1:0]; y1 = ay1[CW-1:0];
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Cycle 0 is the first cycle after the accepting edge; returns at the negedge of done
   task automatic run_until_done(input int budget, input bit stall, output int npix,
                                 output int first_c, output int last_c, output int done_c,
                                 output int busy_c);
      npix = 0; first_c = -1; last_c = -1; done_c = -1; busy_c = 0;
      for (int c = 0; c < budget; c++) begin
         pix_ready = stall ? (c % 3 == 0) : 1'b1;
         @(negedge clk);
         if (busy) busy_c++;
         if (pix_valid && pix_ready) begin
            if (first_c < 0) first_c = c;
            last_c = c;
            npix++;
         end
         if (done) begin
            done_c = c;
            break;
         end
         @(posedge clk); #1;
      end
      pix_ready = 1'b1;
   endtask

   // Scoreboard, stall-hold and done/valid exclusivity monitor
   bit            prev_stall = 1'b0;
   logic [CW-1:0] px, py;
   bit [2*CW-1:0] exp_pix;
   always @(negedge clk) begin
      if (!reset_n) begin
         prev_stall = 1'b0;
      end else begin
         if (done) begin
            n_tests++;
            if (pix_valid !== 1'b0) begin
               n_fail++;
               $display("FAIL done_with_valid: pix_valid=%0b while done, want 0", pix_valid);
            end
         end
         if (prev_stall) begin
            n_tests++;
            if (pix_valid !== 1'b1 || x !== px || y !== py) begin
               n_fail++;
               $display("FAIL stall_hold: got v=%0b (%0d,%0d) want v=1 (%0d,%0d)",
                        pix_valid, x, y, px, py);
            end
         end
         if (pix_valid && pix_ready) begin
            n_tests++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL pixel_extra: got (%0d,%0d) want no pixel", x, y);
            end else begin
               exp_pix = sb.pop_front();
               if ({x, y} !== exp_pix) begin
                  n_fail++;
                  $display("FAIL pixel: got (%0d,%0d) want (%0d,%0d)",
                           x, y, exp_pix[2*CW-1:CW], exp_pix[CW-1:0]);
               end
            end
         end
         prev_stall = pix_valid && !pix_ready;
         px = x;
         py = y;
      end
   end

   task automatic chk(input string name, input int got, input int want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0d want %0d", name, got, want);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0; start = 1'b0; pix_ready = 1'b1;
      x0 = '0; y0 = '0; x1 = '0; y1 = '0;
      repeat (2) @(posedge clk);
      #1;
      if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
      if (pix_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", pix_valid); end
      if (done !== 1'b0)      begin n_fail++; $display("FAIL reset_done: got %0b want 0", done); end
      if (x !== '0 || y !== '0) begin
         n_fail++; $display("FAIL reset_xy: got (%0d,%0d) want (0,0)", x, y);
      end
      n_tests += 4;
      reset_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_shallow();
      int npix, fc, lc, dc, bc;
      start_line(0, 0, 240, 50);
      run_until_done(600, 1'b0, npix, fc, lc, dc, bc);
      chk("shallow_count", npix, 241);
      chk("shallow_first_latency", fc, 1);
      chk("shallow_last_cycle", lc, 241);
      chk("shallow_done_cycle", dc, 242);
      chk("shallow_busy_cycles", bc, 243);
      chk("shallow_sb_left", sb.size(), 0);
      @(posedge clk); #1;
      chk("shallow_busy_after", int'(busy), 0);
   endtask

   task automatic test_steep_neg();
      int npix, fc, lc, dc, bc;
      start_line(100, 100, 90, 130);
      run_until_done(200, 1'b0, npix, fc, lc, dc, bc);
      chk("steep_count", npix, 31);
      chk("steep_done_after_last", dc, lc + 1);
      chk("steep_sb_left", sb.size(), 0);
      @(posedge clk); #1;
   endtask

   task automatic test_single();
      int npix, fc, lc, dc, bc;
      start_line(5, 5, 5, 5);
      run_until_done(20, 1'b0, npix, fc, lc, dc, bc);
      chk("single_count", npix, 1);
      chk("single_busy_cycles", bc, 3);
      chk("single_done_cycle", dc, 2);
      chk("single_sb_left", sb.size(), 0);
      @(posedge clk); #1;
   endtask

   task automatic test_stall();
      int npix, fc, lc, dc, bc;
      start_line(0, 0, 10, 10);
      run_until_done(200, 1'b1, npix, fc, lc, dc, bc);
      chk("stall_count", npix, 11);
      chk("stall_sb_left", sb.size(), 0);
      @(posedge clk); #1;
   endtask

   task automatic test_ignore_start();
      int npix, fc, lc, dc, bc;
      pix_ready = 1'b0;
      start_line(20, 30, 60, 35);
      repeat (3) @(posedge clk);
      #1;
      x0 = 11'd300; y0 = 11'd300; x1 = 11'd310; y1 = 11'd400;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      run_until_done(300, 1'b0, npix, fc, lc, dc, bc);
      chk("ignore_count", npix, 41);
      chk("ignore_sb_left", sb.size(), 0);
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      int npix, fc, lc, dc, bc;
      start_line(7, 3, 3, 1);
      run_until_done(100, 1'b0, npix, fc, lc, dc, bc);
      chk("b2b_first_count", npix, 5);
      // Start raised during the done cycle is seen in DONE, not IDLE
      x0 = 11'd1; y0 = 11'd1; x1 = 11'd2; y1 = 11'd2;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("b2b_ignored_busy", int'(busy), 0);
         chk("b2b_ignored_valid", int'(pix_valid), 0);
      end
      @(posedge clk); #1;
      start_line(1, 1, 3, 2);
      run_until_done(100, 1'b0, npix, fc, lc, dc, bc);
      chk("b2b_second_count", npix, 3);
      chk("b2b_sb_left", sb.size(), 0);
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      int npix, fc, lc, dc, bc, seen;
      start_line(0, 0, 200, 0);
      seen = 0;
      for (int c = 0; c < 100 && seen < 20; c++) begin
         pix_ready = 1'b1;
         @(negedge clk);
         if (pix_valid && pix_ready) seen++;
         if (seen < 20) begin @(posedge clk); #1; end
      end
      chk("midreset_reached", seen, 20);
      #2;
      reset_n = 1'b0;
      #1;
      chk("midreset_busy", int'(busy), 0);
      chk("midreset_valid", int'(pix_valid), 0);
      chk("midreset_x", int'(x), 0);
      sb.delete();
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
      start_line(50, 7, 53, 9);
      run_until_done(100, 1'b0, npix, fc, lc, dc, bc);
      chk("midreset_new_count", npix, 4);
      chk("midreset_sb_left", sb.size(), 0);
      @(posedge clk); #1;
   endtask

`ifdef LINE_CLIP_EN
   task automatic test_clip();
      int npix, fc, lc, dc, bc;
      start_line(630, 0, 650, 0);
      run_until_done(200, 1'b0, npix, fc, lc, dc, bc);
      chk("clip_count", npix, 10);
      chk("clip_done_cycle", dc, 22);
      chk("clip_sb_left", sb.size(), 0);
      @(posedge clk); #1;
   endtask
`endif

   initial begin
      test_reset();
      test_shallow();
      test_steep_neg();
      test_single();
      test_stall();
      test_ignore_start();
      test_back_to_back();
      test_reset_mid();
`ifdef LINE_CLIP_EN
      test_clip();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
